// File: rtl/fetch_redirect_stage.sv
// rtl/fetch_redirect_stage.sv - Instruction fetch with EX-stage branch/JAL/JALR redirect and one-cycle squash
module fetch_redirect_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr_F,
    input  logic [31:0]        alu_result_EX,
    input  logic [31:0]        rs1_data_EX,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        instr_EX,
    output logic [31:0]        pc_EX,
    output logic [31:0]        link_EX,
    output logic               stall_EX
);

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OP_BRANCH  = 7'h63;
    localparam logic [6:0]  OP_JAL     = 7'h6F;
    localparam logic [6:0]  OP_JALR    = 7'h67;

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_ex_q, pc_ex_d;
    logic [31:0] instr_ex_q, instr_ex_d;
    logic        stall_ex_q, stall_ex_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] b_imm, j_imm, i_imm;
    logic        br_taken;
    logic        ctl_taken;
    logic [31:0] target;
    logic        redirect;

    assign opcode = instr_ex_q[6:0];
    assign funct3 = instr_ex_q[14:12];

    assign b_imm = {{20{instr_ex_q[31]}}, instr_ex_q[7], instr_ex_q[30:25], instr_ex_q[11:8], 1'b0};
    assign j_imm = {{12{instr_ex_q[31]}}, instr_ex_q[19:12], instr_ex_q[20], instr_ex_q[30:21], 1'b0};
    assign i_imm = {{20{instr_ex_q[31]}}, instr_ex_q[31:20]};

    // Branch condition from the ALU result the EX stage already computed for this branch
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:          br_taken = (alu_result_EX == 32'd0);
            3'b001:          br_taken = (alu_result_EX != 32'd0);
            3'b100, 3'b110:  br_taken = alu_result_EX[0];
            3'b101, 3'b111:  br_taken = ~alu_result_EX[0];
            default:         br_taken = 1'b0;
        endcase
    end

    // Control-transfer decode and target selection; a bubble in EX never redirects
    always_comb begin
        ctl_taken = 1'b0;
        target    = pc_f_q + 32'd4;
        case (opcode)
            OP_BRANCH: begin
                ctl_taken = br_taken;
                target    = pc_ex_q + b_imm;
            end
            OP_JAL: begin
                ctl_taken = 1'b1;
                target    = pc_ex_q + j_imm;
            end
            OP_JALR: begin
                ctl_taken = 1'b1;
                target    = (rs1_data_EX + i_imm) & 32'hFFFF_FFFC;
            end
            default: begin
                ctl_taken = 1'b0;
            end
        endcase
        redirect = ~stall_ex_q & ctl_taken;
    end

    // Next-state for the PC and the EX slot; the wrong-path fetch becomes a bubble
    always_comb begin
        pc_f_d     = redirect ? target : (pc_f_q + 32'd4);
        pc_ex_d    = pc_f_q;
        instr_ex_d = instr_F;
        stall_ex_d = redirect;
    end

    // Pipeline registers; reset clears any pending redirect and parks EX on a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_q     <= RESET_PC;
            pc_ex_q    <= 32'd0;
            instr_ex_q <= NOP_INSTR;
            stall_ex_q <= 1'b1;
        end else begin
            pc_f_q     <= pc_f_d;
            pc_ex_q    <= pc_ex_d;
            instr_ex_q <= instr_ex_d;
            stall_ex_q <= stall_ex_d;
        end
    end

    assign imem_addr = pc_f_q[IMEM_AW+1:2];
    assign instr_EX  = instr_ex_q;
    assign pc_EX     = pc_ex_q;
    assign link_EX   = pc_ex_q + 32'd4;
    assign stall_EX  = stall_ex_q;

endmodule
